// File: rtl/bf_tape_pointer.sv
// Data-tape cell pointer: single/multi-step moves with wrap or saturate, direct loads, save/restore stack.
// One-cycle latency on every output; no backpressure, one command accepted per enabled cycle.
module bf_tape_pointer #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1000,
  parameter int STEP_W  = 4,
  parameter int STACK_D = 8,
  parameter int WRAP    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             inc,
  input  logic                             dec,
  input  logic [STEP_W-1:0]                step,
  input  logic                             load,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic                             push,
  input  logic                             pop,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                ADR,
  output logic                             wrapped,
  output logic                             err,
  output logic [$clog2(STACK_D+1)-1:0]     stk_cnt,
  output logic                             stk_full,
  output logic                             stk_empty
);

  localparam int CNT_W = $clog2(STACK_D + 1);
  localparam int IDX_W = (STACK_D > 1) ? $clog2(STACK_D) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_X  = (ADDR_W + 1)'(DEPTH - 1);

  logic [ADDR_W-1:0] stack_mem [STACK_D];

  logic [ADDR_W:0]   adr_x, s_x, s_red, sum_x, sum_red;
  logic [ADDR_W-1:0] adr_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_en, wrap_nxt, err_set;

  // One extra bit of headroom: ADR + s never exceeds 2**(ADDR_W+1)-1.
  assign adr_x   = {1'b0, ADR};
  assign s_x     = (step == '0) ? (ADDR_W + 1)'(1) : (ADDR_W + 1)'(step);
  assign s_red   = s_x % DEPTH_X;
  assign sum_x   = adr_x + s_x;
  assign sum_red = adr_x + s_red;

  assign wr_idx    = IDX_W'(stk_cnt);
  assign rd_idx    = IDX_W'(stk_cnt - CNT_W'(1));
  assign stk_full  = (stk_cnt == CNT_W'(STACK_D));
  assign stk_empty = (stk_cnt == '0);

  always_comb begin
    adr_nxt  = ADR;
    cnt_nxt  = stk_cnt;
    wr_en    = 1'b0;
    wrap_nxt = 1'b0;
    err_set  = 1'b0;
    if (en) begin
      if (load) begin
        if ({1'b0, load_addr} < DEPTH_X) adr_nxt = load_addr;
        else                             err_set = 1'b1;
      end else if (pop) begin
        if (!stk_empty) begin
          adr_nxt = stack_mem[rd_idx];
          cnt_nxt = stk_cnt - CNT_W'(1);
        end else begin
          err_set = 1'b1;
        end
      end else if (inc ^ dec) begin
        if (inc) begin
          if (WRAP != 0) begin
            wrap_nxt = (sum_x >= DEPTH_X);
            adr_nxt  = (sum_red >= DEPTH_X) ? ADDR_W'(sum_red - DEPTH_X) : ADDR_W'(sum_red);
          end else if (sum_x > LAST_X) begin
            adr_nxt = ADDR_W'(LAST_X);
            err_set = 1'b1;
          end else begin
            adr_nxt = ADDR_W'(sum_x);
          end
        end else begin
          if (WRAP != 0) begin
            wrap_nxt = (s_x > adr_x);
            adr_nxt  = (adr_x >= s_red) ? ADDR_W'(adr_x - s_red)
                                        : ADDR_W'(adr_x + DEPTH_X - s_red);
          end else if (s_x > adr_x) begin
            adr_nxt = '0;
            err_set = 1'b1;
          end else begin
            adr_nxt = ADDR_W'(adr_x - s_x);
          end
        end
      end else if (push && !inc && !dec) begin
        // inc=dec=1 still counts as the selected move, so push stays blocked.
        if (!stk_full) begin
          wr_en   = 1'b1;
          cnt_nxt = stk_cnt + CNT_W'(1);
        end else begin
          err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ADR     <= '0;
      wrapped <= 1'b0;
      err     <= 1'b0;
      stk_cnt <= '0;
    end else begin
      ADR     <= adr_nxt;
      wrapped <= wrap_nxt;
      stk_cnt <= cnt_nxt;
      err     <= err_set | (err & ~err_clr);
    end
  end

  // Contents are meaningless after reset; only the count needs clearing.
  always_ff @(posedge clk) begin
    if (wr_en) stack_mem[wr_idx] <= ADR;
  end

endmodule

// File: tb/tb_bf_tape_pointer.sv
// Directed bench: a wrapping and a saturating pointer driven by the same command stream.
module tb_bf_tape_pointer;

  logic       clk = 1'b0;
  logic       rst_n, en, inc, dec, load, push, pop, err_clr;
  logic [3:0] step;
  logic [9:0] load_addr;

  logic [9:0] adr_w, adr_s;
  logic       wrp_w, wrp_s, err_w, err_s;
  logic [3:0] cnt_w, cnt_s;
  logic       full_w, full_s, empty_w, empty_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf_tape_pointer #(.ADDR_W(10), .DEPTH(1000), .STEP_W(4), .STACK_D(8), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .dec(dec), .step(step),
    .load(load), .load_addr(load_addr), .push(push), .pop(pop), .err_clr(err_clr),
    .ADR(adr_w), .wrapped(wrp_w), .err(err_w), .stk_cnt(cnt_w),
    .stk_full(full_w), .stk_empty(empty_w)
  );

  bf_tape_pointer #(.ADDR_W(10), .DEPTH(1000), .STEP_W(4), .STACK_D(8), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .dec(dec), .step(step),
    .load(load), .load_addr(load_addr), .push(push), .pop(pop), .err_clr(err_clr),
    .ADR(adr_s), .wrapped(wrp_s), .err(err_s), .stk_cnt(cnt_s),
    .stk_full(full_s), .stk_empty(empty_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    en = 1'b0; inc = 1'b0; dec = 1'b0; step = 4'd0; load = 1'b0;
    load_addr = 10'd0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_inc(input logic [3:0] s);
    clr_inputs(); en = 1'b1; inc = 1'b1; step = s; tick();
  endtask
  task automatic do_dec(input logic [3:0] s);
    clr_inputs(); en = 1'b1; dec = 1'b1; step = s; tick();
  endtask
  task automatic do_load(input logic [9:0] a);
    clr_inputs(); en = 1'b1; load = 1'b1; load_addr = a; tick();
  endtask
  task automatic do_push();
    clr_inputs(); en = 1'b1; push = 1'b1; tick();
  endtask
  task automatic do_pop();
    clr_inputs(); en = 1'b1; pop = 1'b1; tick();
  endtask
  task automatic do_clr();
    clr_inputs(); err_clr = 1'b1; tick();
  endtask
  task automatic do_nop();
    clr_inputs(); tick();
  endtask

  initial begin
    clr_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    chk("rst_adr", adr_w, 0);
    chk("rst_adr_sat", adr_s, 0);
    chk("rst_wrapped", wrp_w, 0);
    chk("rst_err", err_w, 0);
    chk("rst_cnt", cnt_w, 0);
    chk("rst_empty", empty_w, 1);
    chk("rst_full", full_w, 0);

    // step=0 counts as one cell
    for (int i = 0; i < 3; i++) do_inc(4'd0);
    chk("inc0x3_adr", adr_w, 3);
    chk("inc0x3_adr_sat", adr_s, 3);

    do_dec(4'd5);
    chk("dec5_wrap_adr", adr_w, 998);
    chk("dec5_wrap_pulse", wrp_w, 1);
    chk("dec5_wrap_err", err_w, 0);
    chk("dec5_sat_adr", adr_s, 0);
    chk("dec5_sat_err", err_s, 1);
    chk("dec5_sat_nowrap", wrp_s, 0);
    do_nop();
    chk("wrap_pulse_end", wrp_w, 0);

    do_inc(4'd2);
    chk("inc2_wrap_adr", adr_w, 0);
    chk("inc2_wrap_pulse", wrp_w, 1);
    chk("inc2_sat_adr", adr_s, 2);

    do_clr();
    chk("clr_en0_err_sat", err_s, 0);
    chk("clr_en0_wrapped", wrp_w, 0);

    do_load(10'd995);
    chk("load995", adr_w, 995);
    do_inc(4'd9);
    chk("inc9_wrap_adr", adr_w, 4);
    chk("inc9_wrap_pulse", wrp_w, 1);
    chk("inc9_sat_adr", adr_s, 999);
    chk("inc9_sat_err", err_s, 1);
    do_clr();
    chk("clr_err_sat", err_s, 0);

    // exact arrival at the end is not an error
    do_dec(4'd15);
    do_inc(4'd15);
    chk("exact_end_adr", adr_s, 999);
    chk("exact_end_err", err_s, 0);

    do_load(10'd1000);
    chk("load_oob_adr_sat", adr_s, 999);
    chk("load_oob_err_sat", err_s, 1);
    chk("load_oob_adr_wrap", adr_w, 4);
    chk("load_oob_err_wrap", err_w, 1);
    do_clr();

    clr_inputs(); en = 1'b1; load = 1'b1; pop = 1'b1; inc = 1'b1; load_addr = 10'd7; tick();
    chk("prio_load_adr", adr_w, 7);
    chk("prio_load_cnt", cnt_w, 0);
    chk("prio_load_err", err_w, 0);

    clr_inputs(); en = 1'b1; inc = 1'b1; dec = 1'b1; push = 1'b1; tick();
    chk("incdec_adr", adr_w, 7);
    chk("incdec_err", err_w, 0);
    chk("incdec_push_blocked", cnt_w, 0);

    do_load(10'd10);
    for (int i = 0; i < 8; i++) begin
      do_push();
      chk("push_cnt", cnt_w, i + 1);
      if (i < 7) do_inc(4'd1);
    end
    chk("stk_full", full_w, 1);
    chk("stk_top_adr", adr_w, 17);
    do_push();
    chk("push_full_err", err_w, 1);
    chk("push_full_cnt", cnt_w, 8);
    do_clr();

    for (int i = 0; i < 8; i++) begin
      do_pop();
      chk("pop_adr", adr_w, 17 - i);
      chk("pop_cnt", cnt_w, 7 - i);
    end
    chk("stk_empty", empty_w, 1);
    chk("pop_no_err", err_w, 0);
    do_pop();
    chk("pop_empty_err", err_w, 1);
    chk("pop_empty_adr", adr_w, 10);
    do_clr();

    // push then immediately pop after a move returns the saved cell
    do_load(10'd20);
    do_push();
    do_inc(4'd1);
    do_pop();
    chk("push_pop_adr", adr_w, 20);

    do_push(); do_inc(4'd1); do_push(); do_inc(4'd1); do_push();
    chk("pre_en0_cnt", cnt_w, 3);
    chk("pre_en0_adr", adr_w, 22);
    do_load(10'd1001);
    chk("pre_en0_err", err_w, 1);

    for (int i = 0; i < 20; i++) begin
      clr_inputs();
      inc = i[0]; dec = i[1]; load = i[2]; push = ~i[0]; pop = i[3];
      load_addr = 10'd5; step = 4'd3;
      tick();
      chk("en0_wrapped", wrp_w, 0);
    end
    chk("en0_adr", adr_w, 22);
    chk("en0_cnt", cnt_w, 3);
    chk("en0_err_held", err_w, 1);
    do_clr();
    chk("en0_err_clr", err_w, 0);

    do_load(10'd1023);
    clr_inputs(); en = 1'b1; inc = 1'b1; err_clr = 1'b1; rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("midrst_adr", adr_w, 0);
    chk("midrst_cnt", cnt_w, 0);
    chk("midrst_err", err_w, 0);
    chk("midrst_empty", empty_w, 1);
    do_pop();
    chk("midrst_pop_err", err_w, 1);
    chk("midrst_pop_adr", adr_w, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bf_tape_pointer.md
# bf_tape_pointer

Parametrised data-tape pointer for the brainfuck computer. It holds the current cell address and applies the `>` / `<` moves, including run-length-compressed moves. It also handles direct address loads and a small save/restore address stack. It sits between the instruction decoder and the tape RAM address port, and is the synchronous, bounded successor to the single-step edge-triggered pointer.

## Interface
Parameters:
- `ADDR_W`, 10: address width.
- `DEPTH`, 1000: tape length in cells, 2 ≤ DEPTH ≤ 2**ADDR_W. Need not be a power of two.
- `STEP_W`, 4: width of the move amount. STEP_W ≤ ADDR_W.
- `STACK_D`, 8: entries in the save/restore stack, ≥ 1.
- `WRAP`, 1: 1 = modular wrap at tape ends; 0 = saturate at ends.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `en`, in, 1: command enable. When low, all commands are ignored.
- `inc`, in, 1: move up by `step`.
- `dec`, in, 1: move down by `step`.
- `step`, in, STEP_W: move amount. 0 is treated as 1.
- `load`, in, 1: set pointer to `load_addr`.
- `load_addr`, in, ADDR_W: load target.
- `push`, in, 1: save current `ADR` on the stack.
- `pop`, in, 1: restore `ADR` from the top of the stack.
- `err_clr`, in, 1: clear sticky `err`.
- `ADR`, out, ADDR_W: current cell address, registered.
- `wrapped`, out, 1: one-cycle pulse; the last move crossed a tape end in WRAP=1 mode.
- `err`, out, 1: sticky error flag.
- `stk_cnt`, out, clog2(STACK_D+1): number of occupied stack entries.
- `stk_full`, out, 1: `stk_cnt` == STACK_D.
- `stk_empty`, out, 1: `stk_cnt` == 0.

## Operation
- Reset (`rst_n`=0 at a clk edge) sets:
  - `ADR`=0, `wrapped`=0, `err`=0, `stk_cnt`=0, `stk_empty`=1, `stk_full`=0.
  - Stack contents are don't-care.
- When `en`=1, exactly one command executes per cycle, chosen by priority:
  1. `load`
  2. `pop`
  3. move: `inc` XOR `dec`
  4. `push`
- Lower-priority commands asserted in the same cycle are dropped silently.
- `inc`=`dec`=1 is a no-op move. It does not raise `err`, and it does not unblock `push` in that cycle.
- Let s = (`step`==0 ? 1 : `step`).
- Move arithmetic uses an ADDR_W+1-bit intermediate and never relies on natural 2**ADDR_W rollover.
- WRAP=1:
  - inc: `ADR` ← (ADR+s) mod DEPTH.
  - dec: `ADR` ← (ADR−s) mod DEPTH.
  - `wrapped`=1 on the next cycle if the end was crossed.
  - s ≥ DEPTH is still reduced correctly. For any legal STEP_W, at most one wrap occurs per move.
- WRAP=0:
  - inc: `ADR` ← min(ADR+s, DEPTH−1).
  - dec: `ADR` ← max(ADR−s, 0).
  - If clamping occurs, `err` is set. Reaching an end exactly is not an error.
- load:
  - `load_addr` < DEPTH: `ADR` ← `load_addr`.
  - Otherwise `ADR` is unchanged and `err` is set.
- push:
  - Stack not full: stack[stk_cnt] ← ADR and `stk_cnt`+1.
  - Stack full: no change, `err` is set.
- pop:
  - Stack not empty: `ADR` ← stack[stk_cnt−1] and `stk_cnt`−1.
  - Stack empty: `ADR` unchanged, `err` is set.
- `err_clr` acts regardless of `en`. If a new error occurs in the same cycle, the set wins.
- `en`=0: `ADR` and the stack hold, and `wrapped` is 0.

## Timing
- All outputs are registered. A command sampled at edge N is visible on `ADR` / `stk_*` / `err` after edge N, i.e. one-cycle latency.
- Back-to-back commands on consecutive cycles are supported with no bubbles. There is no busy/ready signal.
- `wrapped` is high for exactly the cycle following the wrapping move.
- A push followed next cycle by a pop returns the pushed value. No forwarding is needed, because the stack write completes at the push edge.
- Reset mid-sequence discards any in-flight command and the entire stack.
- Reset has priority over every input, including `err_clr`.

## Test plan
- Default params (WRAP=1, DEPTH=1000):
  - After reset, inc with step=0 three times → ADR=3.
  - dec with step=5 → ADR=998, `wrapped` pulses 1 cycle.
  - inc with step=2 → ADR=0, `wrapped` pulses again.
- WRAP=0, DEPTH=1000:
  - load 995, inc with step=9 → ADR=999, err=1.
  - err_clr → err=0.
  - load 1000 → ADR stays 999, err=1.
- Priority:
  - load=1, pop=1, inc=1, load_addr=7 in one cycle → ADR=7, stk_cnt unchanged.
  - inc=dec=1 with ADR=7 → ADR stays 7, err=0.
- Stack (STACK_D=8):
  - Push ADR=10,11,…,17 (inc between pushes) → stk_full=1.
  - A ninth push → err=1, stk_cnt=8.
  - Eight pops → ADR=17,16,…,10, stk_empty=1.
  - A further pop → err=1, ADR=10.
- Enable/reset:
  - en=0 with inc/load/push toggling for 20 cycles → ADR, stk_cnt unchanged.
  - err_clr still clears err while en=0.
  - rst_n=0 for one edge mid-stream with stk_cnt=3 → ADR=0, stk_cnt=0, err=0.
